// File: rtl/led_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank_if
//  Purpose  : Bundles the event, mode and LED-drive signals of led_bank.
//  Ports    : sig     - per-channel event inputs (NCH)
//             mode    - per-channel display mode, 2 bits per channel
//             led     - registered LED drive (NCH)
//             tick_ms - one-cycle millisecond pulse
//             strobe  - one-cycle pulse every PERIOD ticks
//  Modports : master drives sig/mode, slave (the LED bank) drives the rest.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_bank_if #(
  parameter int NCH = 4
) ();
  logic [NCH-1:0]   sig;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   led;
  logic             tick_ms;
  logic             strobe;

  modport master (
    output sig,
    output mode,
    input  led,
    input  tick_ms,
    input  strobe
  );

  modport slave (
    input  sig,
    input  mode,
    output led,
    output tick_ms,
    output strobe
  );
endinterface
`default_nettype wire

// File: rtl/led_bank.sv
`default_nettype none
// ============================================================================
//  Module   : led_bank
//  Purpose  : Multi-channel status-LED driver. Owns the millisecond prescaler
//             and the slow LED strobe; each channel is a retriggerable pulse
//             stretcher whose output is shaped by a per-channel display mode
//             (stretch, blink, forced off, forced on).
//  Ports    : clk   - system clock
//             rst_n - synchronous active-low reset
//             bus   - led_bank_if.slave (sig, mode in; led, tick_ms, strobe out)
//  Revision : 1.0 - initial release
// ============================================================================
module led_bank #(
  parameter int NCH        = 4,
  parameter int TICK_DIV   = 2500,
  parameter int PERIOD     = 64,
  parameter int HOLD       = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  led_bank_if.slave     bus
);

  localparam int c_ms_w = $clog2(TICK_DIV);
  // A one-tick period still needs a 1-bit counter to stay legal.
  localparam int c_st_w = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [c_ms_w-1:0] c_ms_last = c_ms_w'(TICK_DIV - 1);
  localparam logic [c_st_w-1:0] c_st_last = c_st_w'(PERIOD - 1);
  localparam logic [3:0]        c_hold    = 4'(HOLD);
  localparam logic              c_pol     = (ACTIVE_LOW != 0);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_on   = 1'b1;

  // --------------------------------------------------------------------------
  // Prescaler: millisecond tick, strobe and global blink phase
  // --------------------------------------------------------------------------
  logic [c_ms_w-1:0] ms_cnt_q, ms_cnt_d;
  logic [c_st_w-1:0] st_cnt_q, st_cnt_d;
  logic              tick_ms_q, tick_ms_d;
  logic              strobe_q, strobe_d;
  logic              phase_q, phase_d;
  logic              w_ms_wrap;

  always_comb begin
    w_ms_wrap = (ms_cnt_q == c_ms_last);
    ms_cnt_d  = w_ms_wrap ? '0 : ms_cnt_q + 1'b1;
    st_cnt_d  = st_cnt_q;
    if (w_ms_wrap) begin
      st_cnt_d = (st_cnt_q == c_st_last) ? '0 : st_cnt_q + 1'b1;
    end
    // Both pulses are registered so they line up with each other.
    tick_ms_d = w_ms_wrap;
    strobe_d  = w_ms_wrap && (st_cnt_q == c_st_last);
    phase_d   = phase_q ^ strobe_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_cnt_q  <= '0;
      st_cnt_q  <= '0;
      tick_ms_q <= 1'b0;
      strobe_q  <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      st_cnt_q  <= st_cnt_d;
      tick_ms_q <= tick_ms_d;
      strobe_q  <= strobe_d;
      phase_q   <= phase_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel stretcher and mode selection
  // --------------------------------------------------------------------------
  logic [NCH-1:0] w_on;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0] state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] mode_i;
    logic       on_i;

    assign mode_i = bus.mode[2*i+1 -: 2];

    // State register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= c_st_idle;
        hold_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    // Next state: a trigger always wins over a coincident strobe, so the
    // full hold count is restored and never immediately decremented.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (bus.sig[i]) begin
        state_d    = c_st_on;
        hold_cnt_d = c_hold;
      end else if (state_q == c_st_on && strobe_q) begin
        if (hold_cnt_q == 4'd1) begin
          state_d    = c_st_idle;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
    end

    // Output: the stretcher runs regardless of mode; mode only selects
    // what reaches the LED.
    always_comb begin
      on_i = 1'b0;
      case (mode_i)
        2'b00:   on_i = (state_q == c_st_on);
        2'b01:   on_i = (state_q == c_st_on) && phase_q;
        2'b10:   on_i = 1'b0;
        default: on_i = 1'b1;
      endcase
    end

    assign w_on[i] = on_i;
  end

  // --------------------------------------------------------------------------
  // Registered LED drive with selectable polarity
  // --------------------------------------------------------------------------
  logic [NCH-1:0] led_q, led_d;

  always_comb begin
    led_d = w_on ^ {NCH{c_pol}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= {NCH{c_pol}};
    end else begin
      led_q <= led_d;
    end
  end

  assign bus.led     = led_q;
  assign bus.tick_ms = tick_ms_q;
  assign bus.strobe  = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_bank
//  Purpose  : Self-checking bench for led_bank. A time-based reference model
//             (edges since reset, strobes seen, strobe index of each channel's
//             last trigger) predicts led, tick_ms and strobe every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_bank;
  localparam int NCH  = 4;
  localparam int TD   = 4;
  localparam int P    = 2;
  localparam int HOLD = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_bank_if #(.NCH(NCH)) bus ();

  led_bank #(
    .NCH        (NCH),
    .TICK_DIV   (TD),
    .PERIOD     (P),
    .HOLD       (HOLD),
    .ACTIVE_LOW (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int             k;          // non-reset edges since reset release
  int             scount;     // strobes consumed so far
  int             mark [NCH]; // scount at each channel's last trigger, -1 none
  logic [NCH-1:0] exp_led;
  logic           exp_tick;
  logic           exp_strobe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic lit_sel(input logic [1:0] m, input logic on, input logic ph);
    case (m)
      2'b00:   return on;
      2'b01:   return on & ph;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // One clock: advance the model with the inputs held over this edge, then
  // compare the registered outputs shortly after the edge.
  task automatic step();
    logic [NCH-1:0]   s;
    logic [2*NCH-1:0] m;
    logic             r;
    logic             on;
    s = bus.sig;
    m = bus.mode;
    r = rst_n;
    @(posedge clk);
    if (!r) begin
      k          = 0;
      scount     = 0;
      for (int i = 0; i < NCH; i++) mark[i] = -1;
      exp_led    = '1;
      exp_tick   = 1'b0;
      exp_strobe = 1'b0;
    end else begin
      // Channel lit while fewer than HOLD strobes followed its last trigger.
      for (int i = 0; i < NCH; i++) begin
        on = (mark[i] >= 0) && ((scount - mark[i]) < HOLD);
        exp_led[i] = ~lit_sel(m[2*i +: 2], on, (scount % 2) == 1);
      end
      if (exp_strobe) scount++;
      for (int i = 0; i < NCH; i++) begin
        if (s[i]) mark[i] = scount;
      end
      k++;
      exp_tick   = (k % TD) == 0;
      exp_strobe = (k % (TD * P)) == 0;
    end
    #1;
    chk("led", 32'(bus.led), 32'(exp_led));
    chk("tick_ms", 32'(bus.tick_ms), 32'(exp_tick));
    chk("strobe", 32'(bus.strobe), 32'(exp_strobe));
  endtask

  initial begin
    bus.sig    = '0;
    bus.mode   = '0;
    rst_n      = 1'b0;
    exp_strobe = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // Idle after reset: all dark, tick/strobe cadence only.
    repeat (40) step();

    // Channel 3 held triggered while its mode walks 01 -> 10 -> 11 -> 00.
    bus.sig[3] = 1'b1;
    bus.mode[7:6] = 2'b01; repeat (24) step();
    bus.mode[7:6] = 2'b10; repeat (12) step();
    bus.mode[7:6] = 2'b11; repeat (12) step();
    bus.mode[7:6] = 2'b00; repeat (12) step();
    bus.sig[3] = 1'b0;
    repeat (30) step();

    // Reset in the middle of a channel-0 hold, no retrigger afterwards.
    bus.sig[0] = 1'b1; step();
    bus.sig[0] = 1'b0; repeat (6) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; repeat (30) step();

    // Randomized traffic with occasional mode changes and resets; channel 2
    // is sometimes triggered exactly in a strobe cycle.
    for (int c = 0; c < 1500; c++) begin
      logic [NCH-1:0] s;
      int j;
      int mv;
      s = '0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 39) == 0) s[i] = 1'b1;
      end
      if (exp_strobe && ($urandom_range(0, 1) == 1)) s[2] = 1'b1;
      bus.sig = s;
      if ($urandom_range(0, 59) == 0) begin
        j  = int'($urandom_range(0, NCH - 1));
        mv = int'($urandom_range(0, 5));
        bus.mode[2*j +: 2] = (mv > 3) ? 2'b00 : 2'(mv);
      end
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
